sram_responder: RTL and testbench
=================================

Name: sram_responder

Overview:
- Memory-side responder for the core's fetch and load/store initiators.
- Accepts one read or write request at a time over valid/ready channels, and waits a programmable number of cycles.
- Serves the request from an internal word array and returns a response with a status code.
- Sits between the core's memory bus and simulation memory; provides multi-cycle memory behaviour so the IFU/LSU handshakes get exercised.

Parameters:
- DEPTH, 1024, number of 32-bit words in the backing array.
- BASE, 32'h8000_0000, byte address of word 0.
- LATENCY, 2, wait cycles between request acceptance and response valid (legal 0..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- araddr  in  32  read byte address.
- arvalid  in  1  read request valid.
- arready  out  1  read request accepted.
- rdata  out  32  read data.
- rresp  out  2  read status: 00 OKAY, 10 SLVERR.
- rvalid  out  1  read response valid.
- rready  in  1  initiator accepts the read response.
- awaddr  in  32  write byte address.
- awvalid  in  1  write address valid.
- awready  out  1  write address accepted.
- wdata  in  32  write data.
- wstrb  in  4  byte enables; bit i covers wdata[8i+7:8i].
- wvalid  in  1  write data valid.
- wready  out  1  write data accepted.
- bresp  out  2  write status: 00 OKAY, 10 SLVERR.
- bvalid  out  1  write response valid.
- bready  in  1  initiator accepts the write response.

Behaviour:
- State machine:
  - States: IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP.
  - A 4-bit wait counter and latched address/data/strobe registers.
- Reset (rst low, asynchronous):
  - State goes to IDLE, counter to 0.
  - rdata=0, rresp=0, rvalid=0, bresp=0, bvalid=0.
  - arready, awready and wready are forced 0 while rst is low.
  - Array contents are not reset.
  - Reset mid-transaction abandons the transaction; a pending write not yet committed is discarded.
- Readiness:
  - arready = IDLE.
  - awready = wready = IDLE && !arvalid.
  - A write is accepted only when awvalid and wvalid are both high in the same cycle.
  - Simultaneous valid read and write in IDLE: the read wins and the write stays pending (its readies are 0).
- Acceptance:
  - On the handshake edge, latch the address (plus data and strobe for writes) and load counter=LATENCY.
  - Go to RD_WAIT/WR_WAIT, or directly to RD_RESP/WR_RESP when LATENCY=0.
- Wait: the counter decrements each cycle; when it reaches 0, move to the response state on the next edge.
- Response timing: rvalid/bvalid rises exactly LATENCY+1 cycles after the handshake edge.
- Address decode:
  - idx = (addr-BASE)>>2; addr[1:0] is ignored.
  - In range iff BASE <= addr < BASE+4*DEPTH (compute with 33-bit arithmetic; no wrap).
- Read:
  - On entry to RD_RESP, rdata = mem[idx] and rresp=00.
  - Out of range: rdata=0, rresp=10.
- Write:
  - On entry to WR_RESP, mem[idx] bytes with wstrb set are updated and bresp=00.
  - Out of range: no array change, bresp=10.
  - wstrb=0: no change, bresp=00.
- Response hold:
  - rdata/rresp/rvalid (or bresp/bvalid) hold stable until rready (bready) is high at a clock edge.
  - Then the valid drops and the state returns to IDLE; the next request can be accepted on the following edge.
- Ordering: a read issued after a write's bvalid handshake returns the written data (no hazard window).
- Only one outstanding transaction; no pipelining or reordering.

Test Plan:
- Reset release, LATENCY=2: arvalid with araddr=0x8000_0000 while mem[0]=0x1234_5678 -> arready=1 on the handshake edge; rvalid rises 3 cycles later with rdata=0x1234_5678, rresp=00.
- Write 0xAABB_CCDD, wstrb=4'b0101, to 0x8000_0004 (old value 0x1111_1111), then read it back -> bresp=00, read returns 0x11BB_11DD.
- arvalid and awvalid/wvalid asserted together in IDLE -> read served first (awready=wready=0); the write is accepted only after the rvalid/rready handshake.
- araddr=0x7FFF_FFFC and araddr=BASE+4*DEPTH -> rresp=10, rdata=0. A write to BASE+4*DEPTH -> bresp=10 and the array is unchanged.
- Backpressure: hold rready=0 for 5 cycles after rvalid -> rvalid, rdata and rresp stay constant. rready=1 -> rvalid falls the next edge and arready returns to 1.
- rst pulsed low during WR_WAIT -> all outputs and readies are 0 immediately; a later read of that address returns the pre-write value.
- LATENCY=0 build -> rvalid/bvalid asserted 1 cycle after the handshake.

Source files
------------

// File: rtl/sram_responder_if.sv
// sram_responder_if: request/response bus between a memory initiator (IFU/LSU)
// and the sram_responder.
//   Read  address : araddr, arvalid -> arready
//   Read  data    : rdata, rresp, rvalid -> rready
//   Write addr    : awaddr, awvalid -> awready
//   Write data    : wdata, wstrb, wvalid -> wready
//   Write resp    : bresp, bvalid -> bready
// Modports: master = initiator side, slave = responder side.
interface sram_responder_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/sram_responder.sv
// sram_responder: memory-side responder with a programmable wait time.
// Accepts one read or write at a time, waits LATENCY cycles, then serves the
// request from an internal word array and returns OKAY (00) or SLVERR (10).
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - sram_responder_if.slave (read/write request and response channels)
// Parameters: DEPTH words, BASE byte address of word 0, LATENCY wait cycles (0..15).
module sram_responder #(
    parameter int unsigned DEPTH   = 1024,
    parameter logic [31:0] BASE    = 32'h8000_0000,
    parameter int unsigned LATENCY = 2
) (
    input logic             clk,
    input logic             rst,
    sram_responder_if.slave bus
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  LAT   = 4'(LATENCY);
    localparam logic [32:0] LO    = {1'b0, BASE};
    localparam logic [32:0] HI    = LO + (33'(DEPTH) << 2);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_RESP,
        WR_WAIT,
        WR_RESP
    } state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic        rvalid_q;
    logic [1:0]  bresp_q;
    logic        bvalid_q;

    logic [31:0] mem_q [DEPTH];

    logic [31:0]      off;
    logic [IDX_W-1:0] idx;
    logic             in_range;
    logic             rd_load;
    logic             wr_commit;
    logic             unused_bits;

    // 33-bit compare so addresses near 2^32 cannot wrap into range.
    assign in_range    = ({1'b0, addr_q} >= LO) && ({1'b0, addr_q} < HI);
    assign off         = addr_q - BASE;
    assign idx         = off[IDX_W+1:2];
    assign unused_bits = ^{off[31:IDX_W+2], off[1:0]};

    // The response is produced either when the wait count expires, or (when
    // LATENCY is 0 and the wait state is skipped) on the first cycle in the
    // response state; both give valid LATENCY+1 cycles after acceptance.
    assign rd_load   = (state_q == RD_WAIT && cnt_q == 4'd0) || (state_q == RD_RESP && !rvalid_q);
    assign wr_commit = (state_q == WR_WAIT && cnt_q == 4'd0) || (state_q == WR_RESP && !bvalid_q);

    assign bus.arready = rst && (state_q == IDLE);
    assign bus.awready = rst && (state_q == IDLE) && !bus.arvalid;
    assign bus.wready  = rst && (state_q == IDLE) && !bus.arvalid;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.bresp   = bresp_q;
    assign bus.bvalid  = bvalid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            rdata_q  <= '0;
            rresp_q  <= '0;
            rvalid_q <= 1'b0;
            bresp_q  <= '0;
            bvalid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.arvalid) begin
                        addr_q  <= bus.araddr;
                        cnt_q   <= LAT;
                        state_q <= (LAT == 4'd0) ? RD_RESP : RD_WAIT;
                    end else if (bus.awvalid && bus.wvalid) begin
                        addr_q  <= bus.awaddr;
                        wdata_q <= bus.wdata;
                        wstrb_q <= bus.wstrb;
                        cnt_q   <= LAT;
                        state_q <= (LAT == 4'd0) ? WR_RESP : WR_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (cnt_q == 4'd0) state_q <= RD_RESP;
                    else               cnt_q   <= cnt_q - 4'd1;
                end
                RD_RESP: begin
                    if (rvalid_q && bus.rready) begin
                        rvalid_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                WR_WAIT: begin
                    if (cnt_q == 4'd0) state_q <= WR_RESP;
                    else               cnt_q   <= cnt_q - 4'd1;
                end
                WR_RESP: begin
                    if (bvalid_q && bus.bready) begin
                        bvalid_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (rd_load) begin
                rvalid_q <= 1'b1;
                rdata_q  <= in_range ? mem_q[idx] : '0;
                rresp_q  <= in_range ? 2'b00 : 2'b10;
            end
            if (wr_commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= in_range ? 2'b00 : 2'b10;
            end
        end
    end

    // Backing array: never reset; written only at commit, so a write abandoned
    // by reset leaves it untouched.
    always_ff @(posedge clk) begin
        if (wr_commit && in_range) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wstrb_q[i]) mem_q[idx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: directed self-checking bench for sram_responder.
// u_dut uses LATENCY=2, DEPTH=1024; u_dut0 uses LATENCY=0, DEPTH=16.
module tb_sram_responder;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   errors  = 0;

    sram_responder_if bus ();
    sram_responder_if bus0 ();

    sram_responder #(.DEPTH(1024), .BASE(BASE), .LATENCY(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    sram_responder #(.DEPTH(16), .BASE(BASE), .LATENCY(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        bus.araddr = '0;  bus.arvalid = 0;  bus.rready = 0;
        bus.awaddr = '0;  bus.awvalid = 0;  bus.wdata = '0;
        bus.wstrb = '0;   bus.wvalid = 0;   bus.bready = 0;
        bus0.araddr = '0; bus0.arvalid = 0; bus0.rready = 0;
        bus0.awaddr = '0; bus0.awvalid = 0; bus0.wdata = '0;
        bus0.wstrb = '0;  bus0.wvalid = 0;  bus0.bready = 0;
    endtask

    // Read on bus (z=0) or bus0 (z=1). lat = cycles from handshake edge to rvalid.
    task automatic bus_read(input bit z, input logic [31:0] a, output logic [31:0] d,
                            output logic [1:0] r, output int lat, output bit hs);
        hs = 0;
        if (z) begin bus0.araddr = a; bus0.arvalid = 1; end
        else   begin bus.araddr  = a; bus.arvalid  = 1; end
        for (int n = 0; n < 20 && !hs; n++) begin
            @(negedge clk);
            hs = z ? bus0.arready : bus.arready;
            @(posedge clk); #1;
        end
        bus0.arvalid = 0; bus.arvalid = 0;
        lat = 0;
        while (!(z ? bus0.rvalid : bus.rvalid) && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        d = z ? bus0.rdata : bus.rdata;
        r = z ? bus0.rresp : bus.rresp;
        if (!hs) lat = -1;
        if (z) bus0.rready = 1; else bus.rready = 1;
        @(posedge clk); #1;
        bus0.rready = 0; bus.rready = 0;
    endtask

    task automatic bus_write(input bit z, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] r, output int lat,
                             output bit hs);
        hs = 0;
        if (z) begin bus0.awaddr = a; bus0.wdata = d; bus0.wstrb = s; bus0.awvalid = 1; bus0.wvalid = 1; end
        else   begin bus.awaddr  = a; bus.wdata  = d; bus.wstrb  = s; bus.awvalid  = 1; bus.wvalid  = 1; end
        for (int n = 0; n < 20 && !hs; n++) begin
            @(negedge clk);
            hs = z ? (bus0.awready && bus0.wready) : (bus.awready && bus.wready);
            @(posedge clk); #1;
        end
        bus0.awvalid = 0; bus0.wvalid = 0; bus.awvalid = 0; bus.wvalid = 0;
        lat = 0;
        while (!(z ? bus0.bvalid : bus.bvalid) && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        r = z ? bus0.bresp : bus.bresp;
        if (!hs) lat = -1;
        if (z) bus0.bready = 1; else bus.bready = 1;
        @(posedge clk); #1;
        bus0.bready = 0; bus.bready = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        #2 rst = 0;
        bus.awvalid = 1; bus.wvalid = 1;
        #1;
        vectors++;
        if ({bus.arready, bus.awready, bus.wready} !== 3'b000) begin
            errors++; $display("FAIL reset_readies: got %b expected 000", {bus.arready, bus.awready, bus.wready});
        end
        vectors++;
        if ({bus.rvalid, bus.bvalid, bus.rresp, bus.bresp, bus.rdata} !== '0) begin
            errors++; $display("FAIL reset_outputs: got rv=%b bv=%b rresp=%b bresp=%b rdata=%h expected all 0",
                               bus.rvalid, bus.bvalid, bus.rresp, bus.bresp, bus.rdata);
        end
        idle_inputs();
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        vectors++;
        if ({bus.arready, bus.awready, bus.wready} !== 3'b111) begin
            errors++; $display("FAIL reset_release_ready: got %b expected 111", {bus.arready, bus.awready, bus.wready});
        end
    endtask

    task automatic test_basic_read();
        logic [31:0] d; logic [1:0] r; int lat; bit hs;
        bus_write(0, BASE, 32'h1234_5678, 4'hF, r, lat, hs);
        vectors++;
        if (!hs || r !== 2'b00 || lat != 3) begin
            errors++; $display("FAIL init_write: got hs=%0b bresp=%b lat=%0d expected 1/00/3", hs, r, lat);
        end
        bus_read(0, BASE, d, r, lat, hs);
        vectors++;
        if (!hs) begin errors++; $display("FAIL read_arready: got 0 expected 1"); end
        vectors++;
        if (lat != 3) begin errors++; $display("FAIL read_latency: got %0d expected 3", lat); end
        vectors++;
        if (d !== 32'h1234_5678 || r !== 2'b00) begin
            errors++; $display("FAIL read_base: got %h/%b expected 12345678/00", d, r);
        end
    endtask

    task automatic test_strobe();
        logic [31:0] d; logic [1:0] r; int lat; bit hs;
        bus_write(0, BASE + 32'd4, 32'h1111_1111, 4'hF, r, lat, hs);
        bus_write(0, BASE + 32'd4, 32'hAABB_CCDD, 4'b0101, r, lat, hs);
        vectors++;
        if (r !== 2'b00) begin errors++; $display("FAIL strobe_bresp: got %b expected 00", r); end
        bus_read(0, BASE + 32'd4, d, r, lat, hs);
        vectors++;
        if (d !== 32'h11BB_11DD) begin errors++; $display("FAIL strobe_data: got %h expected 11bb11dd", d); end
        bus_write(0, BASE + 32'd4, 32'hFFFF_FFFF, 4'b0000, r, lat, hs);
        vectors++;
        if (r !== 2'b00) begin errors++; $display("FAIL strobe0_bresp: got %b expected 00", r); end
        // Unaligned address selects the same word.
        bus_read(0, BASE + 32'd7, d, r, lat, hs);
        vectors++;
        if (d !== 32'h11BB_11DD || r !== 2'b00) begin
            errors++; $display("FAIL strobe0_data: got %h/%b expected 11bb11dd/00", d, r);
        end
    endtask

    task automatic test_collision();
        logic [31:0] d; logic [1:0] r; int lat; bit hs;
        int n; int viol;
        bus.araddr = BASE; bus.arvalid = 1;
        bus.awaddr = BASE + 32'd8; bus.wdata = 32'h0F1E_2D3C; bus.wstrb = 4'hF;
        bus.awvalid = 1; bus.wvalid = 1;
        #1;
        vectors++;
        if ({bus.arready, bus.awready, bus.wready} !== 3'b100) begin
            errors++; $display("FAIL coll_readies: got %b expected 100", {bus.arready, bus.awready, bus.wready});
        end
        @(posedge clk); #1;
        bus.arvalid = 0;
        n = 0; viol = 0;
        while (!bus.rvalid && n < 20) begin
            if (bus.awready || bus.wready || bus.bvalid) viol++;
            @(posedge clk); #1; n++;
        end
        if (bus.awready || bus.wready) viol++;
        vectors++;
        if (viol != 0 || n != 3) begin
            errors++; $display("FAIL coll_write_held: got viol=%0d lat=%0d expected 0/3", viol, n);
        end
        vectors++;
        if (bus.rdata !== 32'h1234_5678) begin
            errors++; $display("FAIL coll_rdata: got %h expected 12345678", bus.rdata);
        end
        bus.rready = 1;
        @(posedge clk); #1;
        bus.rready = 0;
        vectors++;
        if ({bus.awready, bus.wready} !== 2'b11) begin
            errors++; $display("FAIL coll_write_ready: got %b expected 11", {bus.awready, bus.wready});
        end
        bus_write(0, BASE + 32'd8, 32'h0F1E_2D3C, 4'hF, r, lat, hs);
        vectors++;
        if (!hs || r !== 2'b00 || lat != 3) begin
            errors++; $display("FAIL coll_write: got hs=%0b bresp=%b lat=%0d expected 1/00/3", hs, r, lat);
        end
        // Read straight after the write response handshake.
        bus_read(0, BASE + 32'd8, d, r, lat, hs);
        vectors++;
        if (d !== 32'h0F1E_2D3C) begin errors++; $display("FAIL back_to_back: got %h expected 0f1e2d3c", d); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] d; logic [1:0] r; int lat; bit hs;
        logic [31:0] addrs [3];
        addrs[0] = 32'h7FFF_FFFC; addrs[1] = 32'h8000_1000; addrs[2] = 32'hFFFF_FFFC;
        for (int i = 0; i < 3; i++) begin
            bus_read(0, addrs[i], d, r, lat, hs);
            vectors++;
            if (d !== 32'h0 || r !== 2'b10 || lat != 3) begin
                errors++; $display("FAIL oor_read[%0d]: got %h/%b lat=%0d expected 00000000/10/3", i, d, r, lat);
            end
        end
        bus_write(0, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF, r, lat, hs);
        vectors++;
        if (r !== 2'b10) begin errors++; $display("FAIL oor_bresp: got %b expected 10", r); end
        bus_read(0, BASE, d, r, lat, hs);
        vectors++;
        if (d !== 32'h1234_5678) begin errors++; $display("FAIL oor_no_alias: got %h expected 12345678", d); end
        bus_write(0, 32'h8000_0FFC, 32'h0BAD_CAFE, 4'hF, r, lat, hs);
        bus_read(0, 32'h8000_0FFC, d, r, lat, hs);
        vectors++;
        if (d !== 32'h0BAD_CAFE || r !== 2'b00) begin
            errors++; $display("FAIL last_word: got %h/%b expected 0badcafe/00", d, r);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d0; logic [1:0] r0; int n; int viol;
        bus.araddr = BASE + 32'd4; bus.arvalid = 1;
        @(posedge clk); #1;
        bus.arvalid = 0;
        n = 0;
        while (!bus.rvalid && n < 20) begin @(posedge clk); #1; n++; end
        d0 = bus.rdata; r0 = bus.rresp;
        vectors++;
        if (d0 !== 32'h11BB_11DD || r0 !== 2'b00) begin
            errors++; $display("FAIL bp_first: got %h/%b expected 11bb11dd/00", d0, r0);
        end
        viol = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (!bus.rvalid || bus.rdata !== 32'h11BB_11DD || bus.rresp !== 2'b00 || bus.arready) viol++;
        end
        vectors++;
        if (viol != 0) begin errors++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", viol); end
        bus.rready = 1;
        @(posedge clk); #1;
        bus.rready = 0;
        vectors++;
        if ({bus.rvalid, bus.arready} !== 2'b01) begin
            errors++; $display("FAIL bp_release: got rvalid/arready=%b expected 01", {bus.rvalid, bus.arready});
        end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] d; logic [1:0] r; int lat; bit hs;
        bus_write(0, BASE + 32'd12, 32'h5555_5555, 4'hF, r, lat, hs);
        bus.awaddr = BASE + 32'd12; bus.wdata = 32'h0BAD_F00D; bus.wstrb = 4'hF;
        bus.awvalid = 1; bus.wvalid = 1;
        @(posedge clk); #1;
        bus.awvalid = 0; bus.wvalid = 0;
        @(posedge clk); #1;
        bus.arvalid = 1; bus.awvalid = 1; bus.wvalid = 1;
        rst = 0;
        #1;
        vectors++;
        if ({bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid} !== 5'b0 ||
            {bus.rdata, bus.rresp, bus.bresp} !== '0) begin
            errors++; $display("FAIL rst_mid_outputs: got rdy=%b rv=%b bv=%b rdata=%h rresp=%b bresp=%b expected all 0",
                               {bus.arready, bus.awready, bus.wready}, bus.rvalid, bus.bvalid,
                               bus.rdata, bus.rresp, bus.bresp);
        end
        idle_inputs();
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        bus_read(0, BASE + 32'd12, d, r, lat, hs);
        vectors++;
        if (d !== 32'h5555_5555) begin errors++; $display("FAIL rst_mid_discard: got %h expected 55555555", d); end
    endtask

    task automatic test_latency0();
        logic [31:0] d; logic [1:0] r; int lat; bit hs;
        bus_write(1, BASE + 32'd4, 32'hCAFE_F00D, 4'hF, r, lat, hs);
        vectors++;
        if (!hs || lat != 1 || r !== 2'b00) begin
            errors++; $display("FAIL lat0_write: got hs=%0b lat=%0d bresp=%b expected 1/1/00", hs, lat, r);
        end
        bus_read(1, BASE + 32'd4, d, r, lat, hs);
        vectors++;
        if (!hs || lat != 1 || d !== 32'hCAFE_F00D || r !== 2'b00) begin
            errors++; $display("FAIL lat0_read: got hs=%0b lat=%0d data=%h rresp=%b expected 1/1/cafef00d/00", hs, lat, d, r);
        end
        bus_read(1, BASE + 32'd64, d, r, lat, hs);
        vectors++;
        if (lat != 1 || d !== 32'h0 || r !== 2'b10) begin
            errors++; $display("FAIL lat0_oor: got lat=%0d data=%h rresp=%b expected 1/00000000/10", lat, d, r);
        end
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_strobe();
        test_collision();
        test_out_of_range();
        test_backpressure();
        test_reset_mid_write();
        test_latency0();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
